// File: rtl/rr_sel_arbiter.sv
// Round-robin packet-locking arbiter driving the select of a downstream N-way data mux.
// Holds a grant until the last beat transfers or the beat limit forces a release.
module rr_sel_arbiter #(
    parameter int SEL_WIDTH = 2,
    parameter int MAX_BEATS = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [(1<<SEL_WIDTH)-1:0] req,
    input  logic [(1<<SEL_WIDTH)-1:0] req_last,
    input  logic                      out_ready,
    output logic [SEL_WIDTH-1:0]      sel,
    output logic [(1<<SEL_WIDTH)-1:0] grant,
    output logic                      grant_valid,
    output logic                      locked,
    output logic                      err_overrun
);

    localparam int N = 1 << SEL_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_BEATS - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state, state_nxt;
    logic [SEL_WIDTH-1:0] ptr, ptr_nxt, sel_nxt;
    logic [N-1:0]         grant_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic                 locked_nxt, ovr_nxt;

    logic [SEL_WIDTH-1:0] ptr_eop;
    logic [SEL_WIDTH:0]   pick_idle, pick_eop;
    logic                 xfer, at_limit, eop, forced;

    // Scan from base downwards in priority so the closest requester overwrites the rest.
    function automatic logic [SEL_WIDTH:0] pick(input logic [N-1:0] r,
                                                input logic [SEL_WIDTH-1:0] base);
        logic [SEL_WIDTH-1:0] idx;
        logic [SEL_WIDTH-1:0] win;
        logic                 found;
        win   = '0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = base + SEL_WIDTH'(k);
            if (r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return {found, win};
    endfunction

    function automatic logic [N-1:0] onehot(input logic [SEL_WIDTH-1:0] idx);
        return {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign grant_valid = rst_n && locked && req[sel];
    assign xfer        = grant_valid && out_ready;
    assign at_limit    = (cnt == LAST_CNT);
    assign eop         = xfer && (req_last[sel] || at_limit);
    assign forced      = xfer && !req_last[sel] && at_limit;
    assign ptr_eop     = sel + SEL_WIDTH'(1);
    assign pick_idle   = pick(req, ptr);
    assign pick_eop    = pick(req, ptr_eop);

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        grant_nxt  = grant;
        locked_nxt = locked;
        ptr_nxt    = ptr;
        cnt_nxt    = cnt;
        ovr_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_idle[SEL_WIDTH]) begin
                    state_nxt  = GRANT;
                    sel_nxt    = pick_idle[SEL_WIDTH-1:0];
                    grant_nxt  = onehot(pick_idle[SEL_WIDTH-1:0]);
                    locked_nxt = 1'b1;
                    cnt_nxt    = '0;
                end
            end
            GRANT: begin
                if (eop) begin
                    ptr_nxt = ptr_eop;
                    ovr_nxt = forced;
                    cnt_nxt = '0;
                    // Handover is computed against the advanced pointer: no idle bubble.
                    if (pick_eop[SEL_WIDTH]) begin
                        sel_nxt   = pick_eop[SEL_WIDTH-1:0];
                        grant_nxt = onehot(pick_eop[SEL_WIDTH-1:0]);
                    end else begin
                        state_nxt  = IDLE;
                        grant_nxt  = '0;
                        locked_nxt = 1'b0;
                    end
                end else if (xfer) begin
                    cnt_nxt = cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_nxt  = IDLE;
                grant_nxt  = '0;
                locked_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= '0;
            grant       <= '0;
            locked      <= 1'b0;
            err_overrun <= 1'b0;
            ptr         <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            grant       <= grant_nxt;
            locked      <= locked_nxt;
            err_overrun <= ovr_nxt;
            ptr         <= ptr_nxt;
            cnt         <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter (4 channels, beat limit 4) with hand-computed expectations.
module tb_rr_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] req_last;
    logic       out_ready;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       grant_valid;
    logic       locked;
    logic       err_overrun;

    int checks = 0;
    int errors = 0;

    rr_sel_arbiter #(.SEL_WIDTH(2), .MAX_BEATS(4), .CNT_WIDTH(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_last(req_last),
        .out_ready(out_ready),
        .sel(sel),
        .grant(grant),
        .grant_valid(grant_valid),
        .locked(locked),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with every channel requesting
        rst_n = 1'b0; req = 4'b1111; req_last = 4'b0000; out_ready = 1'b0;
        tick(); tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_gvalid", 32'(grant_valid), 32'h0);
        chk("rst_ovr", 32'(err_overrun), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("first_grant", 32'(grant), 32'h1);
        chk("first_sel", 32'(sel), 32'h0);
        chk("first_locked", 32'(locked), 32'h1);

        // Round-robin with 1-beat packets
        req_last = 4'b1111; out_ready = 1'b1;
        tick(); chk("rr_sel1", 32'(sel), 32'h1);
        tick(); chk("rr_sel2", 32'(sel), 32'h2);
        tick(); chk("rr_sel3", 32'(sel), 32'h3);
        tick(); chk("rr_sel0", 32'(sel), 32'h0);
        chk("rr_grant0", 32'(grant), 32'h1);
        tick(); chk("rr_sel1b", 32'(sel), 32'h1);

        // Packet lock with stall
        rst_n = 1'b0; req = 4'b0000; req_last = 4'b0000; out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_grant", 32'(grant), 32'h0);
        chk("idle_locked", 32'(locked), 32'h0);
        req = 4'b0100;
        tick();
        chk("stall_sel_a", 32'(sel), 32'h2);
        chk("stall_grant_a", 32'(grant), 32'h4);
        req = 4'b0101; out_ready = 1'b1;
        tick(); chk("stall_beat1", 32'(sel), 32'h2);
        out_ready = 1'b0;
        tick(); chk("stall_c1", 32'(sel), 32'h2);
        tick(); chk("stall_c2", 32'(sel), 32'h2);
        chk("stall_gvalid", 32'(grant_valid), 32'h1);
        out_ready = 1'b1;
        tick(); chk("stall_beat2", 32'(sel), 32'h2);
        req_last = 4'b0100;
        tick();
        chk("stall_handover_sel", 32'(sel), 32'h0);
        chk("stall_handover_grant", 32'(grant), 32'h1);
        chk("stall_no_ovr", 32'(err_overrun), 32'h0);

        // Mid-packet request drop
        rst_n = 1'b0; req = 4'b0000; req_last = 4'b0000; out_ready = 1'b0;
        tick();
        rst_n = 1'b1; req = 4'b0010;
        tick();
        chk("drop_grant_a", 32'(grant), 32'h2);
        req = 4'b1010; out_ready = 1'b1;
        tick();
        req = 4'b1000;
        #1 chk("drop_gvalid", 32'(grant_valid), 32'h0);
        tick(); chk("drop_grant1", 32'(grant), 32'h2);
        tick(); chk("drop_grant2", 32'(grant), 32'h2);
        req_last = 4'b0010;
        tick(); chk("drop_grant3", 32'(grant), 32'h2);
        chk("drop_gvalid3", 32'(grant_valid), 32'h0);
        req = 4'b1010;
        #1 chk("drop_gvalid_back", 32'(grant_valid), 32'h1);
        tick();
        chk("drop_handover_sel", 32'(sel), 32'h3);
        chk("drop_handover_grant", 32'(grant), 32'h8);

        // Overrun with beat limit 4
        rst_n = 1'b0; req = 4'b0000; req_last = 4'b0000; out_ready = 1'b0;
        tick();
        rst_n = 1'b1; req = 4'b0001;
        tick();
        req = 4'b0011; out_ready = 1'b1;
        tick(); chk("ovr_b1", 32'(sel), 32'h0);
        tick(); chk("ovr_b2", 32'(sel), 32'h0);
        tick(); chk("ovr_b3", 32'(sel), 32'h0);
        chk("ovr_b3_pulse", 32'(err_overrun), 32'h0);
        tick();
        chk("ovr_sel", 32'(sel), 32'h1);
        chk("ovr_grant", 32'(grant), 32'h2);
        chk("ovr_pulse", 32'(err_overrun), 32'h1);
        out_ready = 1'b0;
        tick();
        chk("ovr_pulse_end", 32'(err_overrun), 32'h0);
        chk("ovr_hold", 32'(sel), 32'h1);

        // Wrap then reset abort
        rst_n = 1'b0; req = 4'b0000; req_last = 4'b0000; out_ready = 1'b0;
        tick();
        rst_n = 1'b1; req = 4'b1000;
        tick();
        chk("wrap_sel3", 32'(sel), 32'h3);
        req = 4'b1011; req_last = 4'b1000; out_ready = 1'b1;
        tick();
        chk("wrap_sel0", 32'(sel), 32'h0);
        chk("wrap_grant0", 32'(grant), 32'h1);
        req_last = 4'b0001;
        tick();
        chk("wrap_sel1", 32'(sel), 32'h1);
        req = 4'b0011; req_last = 4'b0000;
        tick();
        rst_n = 1'b0;
        tick();
        chk("abort_grant", 32'(grant), 32'h0);
        chk("abort_locked", 32'(locked), 32'h0);
        chk("abort_sel", 32'(sel), 32'h0);
        chk("abort_ovr", 32'(err_overrun), 32'h0);
        chk("abort_gvalid", 32'(grant_valid), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("post_abort_sel", 32'(sel), 32'h0);
        chk("post_abort_grant", 32'(grant), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
